// File: rtl/comm_pkg.sv
// Shared constants for the copter command link: opcodes, ack byte, frame-state encoding, default baud divider.
package comm_pkg;

  localparam logic [7:0] REQ_BATT  = 8'h01;
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;
  localparam logic [7:0] POS_ACK   = 8'hA5;

  localparam int DEF_BAUD_DIV = 2604;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GOT_CMD = 2'd1,
    GOT_HI  = 2'd2
  } frm_state_t;

endpackage

// File: rtl/comm_responder_uart_xcvr.sv
// Bit-level UART transceiver: 8N1 receiver with mid-bit sampling and an independent 8N1 transmitter.
module uart_xcvr
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       rx_err,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_MAX  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] BAUD_PRE  = CW'(BAUD_DIV - 2);

  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic          rx_act_q, rx_act_d;
  logic [CW-1:0] rx_baud_q, rx_baud_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_rdy_q, rx_rdy_d;
  logic          rx_err_q, rx_err_d;

  logic          tx_busy_q, tx_busy_d;
  logic [CW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic          tx_done_q, tx_done_d;

  // Receiver: falling edge on the synchronised line arms the byte; bit index 0 is start, 9 is stop.
  always_comb begin
    rx_act_d   = rx_act_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_rdy_d   = 1'b0;
    rx_err_d   = 1'b0;
    if (!rx_act_q) begin
      if (rx_s3_q && !rx_s2_q) begin
        rx_act_d  = 1'b1;
        rx_baud_d = '0;
        rx_bit_d  = 4'd0;
      end else begin
        rx_baud_d = '0;
      end
    end else begin
      rx_baud_d = (rx_baud_q == BAUD_MAX) ? '0 : rx_baud_q + CW'(1);
      if (rx_baud_q == BAUD_MAX) rx_bit_d = rx_bit_q + 4'd1;
      else rx_bit_d = rx_bit_q;
      if (rx_baud_q == BAUD_HALF) begin
        if (rx_bit_q == 4'd9) begin
          rx_act_d = 1'b0;
          if (rx_s2_q) begin
            rx_rdy_d  = 1'b1;
            rx_data_d = rx_shift_q;
          end else begin
            rx_err_d = 1'b1;
          end
        end else if (rx_bit_q != 4'd0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        end else begin
          rx_shift_d = rx_shift_q;
        end
      end else begin
        rx_shift_d = rx_shift_q;
      end
    end
  end

  // Transmitter: the frame sits in a 10-bit shifter whose LSB is the line; ones refill it so TX idles high.
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_done_d  = 1'b0;
    if (!tx_busy_q) begin
      if (trmt) begin
        tx_busy_d  = 1'b1;
        tx_baud_d  = '0;
        tx_bit_d   = 4'd0;
        tx_shift_d = {1'b1, tx_data, 1'b0};
      end else begin
        tx_shift_d = '1;
      end
    end else begin
      tx_done_d = (tx_bit_q == 4'd9) && (tx_baud_q == BAUD_PRE);
      if (tx_baud_q == BAUD_MAX) begin
        tx_baud_d  = '0;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
        else tx_bit_d = tx_bit_q + 4'd1;
      end else begin
        tx_baud_d = tx_baud_q + CW'(1);
      end
    end
  end

  // State registers for both directions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_act_q   <= 1'b0;
      rx_baud_q  <= '0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_rdy_q   <= 1'b0;
      rx_err_q   <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_baud_q  <= '0;
      tx_bit_q   <= 4'd0;
      tx_shift_q <= '1;
      tx_done_q  <= 1'b0;
    end else begin
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_act_q   <= rx_act_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_rdy_q   <= rx_rdy_d;
      rx_err_q   <= rx_err_d;
      tx_busy_q  <= tx_busy_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign TX      = tx_shift_q[0];
  assign rx_data = rx_data_q;
  assign rx_rdy  = rx_rdy_q;
  assign rx_err  = rx_err_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: rtl/comm_responder.sv
// Copter-side command link: assembles 3-byte frames into {cmd,data} and returns a 1-byte response.
// Optional FRAME_TIMEOUT_EN drops a partial frame after TIMEOUT_CYC idle clocks.
module comm_responder
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
`ifdef FRAME_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 2500000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_busy,
  output logic        resp_sent,
  output logic        frm_err
);

  logic [7:0]  rx_data_s;
  logic        rx_rdy_s, rx_err_s;
  frm_state_t  state_q, state_d;
  logic [7:0]  cmd_sh_q, cmd_sh_d, hi_sh_q, hi_sh_d, cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic        cmd_rdy_q, cmd_rdy_d, frm_err_q, frm_err_d;
`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

  uart_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .TX      (TX),
    .rx_data (rx_data_s),
    .rx_rdy  (rx_rdy_s),
    .rx_err  (rx_err_s),
    .tx_data (resp),
    .trmt    (send_resp),
    .tx_busy (resp_busy),
    .tx_done (resp_sent)
  );

  // Frame assembly; completion is evaluated after the clear so it wins a same-cycle acknowledge.
  always_comb begin
    state_d   = state_q;
    cmd_sh_d  = cmd_sh_q;
    hi_sh_d   = hi_sh_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    frm_err_d = 1'b0;
    cmd_rdy_d = clr_cmd_rdy ? 1'b0 : cmd_rdy_q;
    if (rx_err_s) begin
      state_d   = IDLE;
      frm_err_d = 1'b1;
    end else if (rx_rdy_s) begin
      case (state_q)
        IDLE: begin
          cmd_sh_d  = rx_data_s;
          cmd_rdy_d = 1'b0;
          state_d   = GOT_CMD;
        end
        GOT_CMD: begin
          hi_sh_d = rx_data_s;
          state_d = GOT_HI;
        end
        GOT_HI: begin
          cmd_d     = cmd_sh_q;
          data_d    = {hi_sh_q, rx_data_s};
          cmd_rdy_d = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
`ifdef FRAME_TIMEOUT_EN
    if (state_q == IDLE || rx_rdy_s || rx_err_s) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
      to_cnt_d  = '0;
      state_d   = IDLE;
      frm_err_d = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
`endif
  end

  // Frame state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_sh_q  <= 8'h00;
      hi_sh_q   <= 8'h00;
      cmd_q     <= 8'h00;
      data_q    <= 16'h0000;
      cmd_rdy_q <= 1'b0;
      frm_err_q <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_sh_q  <= cmd_sh_d;
      hi_sh_q   <= hi_sh_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      cmd_rdy_q <= cmd_rdy_d;
      frm_err_q <= frm_err_d;
`ifdef FRAME_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  assign cmd     = cmd_q;
  assign data    = data_q;
  assign cmd_rdy = cmd_rdy_q;
  assign frm_err = frm_err_q;

endmodule
